// File: rtl/nway_wb_cache.sv
// nway_wb_cache
//   N-way set-associative, write-back, write-allocate data cache with NRU
//   replacement. One core request is in flight at a time. Dirty victims leave
//   over a valid/ready memory request channel (posted write), and the line
//   fill comes back on a response strobe. It also keeps hit, miss and
//   write-back counters.
//
// Ports
//   clk_i, rst_i         clock; synchronous active-high reset
//   req_*_i / req_ready_o core request (ready only while idle)
//   rsp_*_o              one-cycle completion pulse with read data and hit flag
//   mem_req_*            line-wide memory request (write-back or fill)
//   mem_rsp_*_i          fill data strobe (only honoured while waiting for it)
//   *_count_o            free-running statistics counters (wrap)
module nway_wb_cache #(
   parameter int WAYS          = 4,
   parameter int SETS          = 256,
   parameter int LINE_BYTES    = 64,
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic                      req_we_i,
   input  logic [ADDRESS_WIDTH-1:0]  req_addr_i,
   input  logic [DATA_WIDTH-1:0]     req_wdata_i,
   output logic                      rsp_valid_o,
   output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
   output logic                      rsp_hit_o,
   output logic                      mem_req_valid_o,
   input  logic                      mem_req_ready_i,
   output logic                      mem_req_we_o,
   output logic [ADDRESS_WIDTH-1:0]  mem_req_addr_o,
   output logic [LINE_BYTES*8-1:0]   mem_req_wline_o,
   input  logic                      mem_rsp_valid_i,
   input  logic [LINE_BYTES*8-1:0]   mem_rsp_line_i,
   output logic [31:0]               hit_count_o,
   output logic [31:0]               miss_count_o,
   output logic [31:0]               wb_count_o
);

   localparam int OFFSET_BITS = $clog2(LINE_BYTES);
   localparam int INDEX_BITS  = $clog2(SETS);
   localparam int TAG_BITS    = ADDRESS_WIDTH - INDEX_BITS - OFFSET_BITS;
   localparam int LINE_W      = LINE_BYTES * 8;
   localparam int WORDS       = LINE_W / DATA_WIDTH;
   localparam int WSEL        = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int WAY_BITS    = $clog2(WAYS);
   localparam int BYTE_BITS   = $clog2(DATA_WIDTH / 8);

   typedef struct packed {
      logic                     we;
      logic [ADDRESS_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0]    wdata;
   } core_req_t;

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL, S_WAIT} state_e;

   // ---------------------------------------------------------------- storage
   logic [WAYS-1:0]     valid_q [SETS];
   logic [WAYS-1:0]     dirty_q [SETS];
   logic [WAYS-1:0]     use_q   [SETS];
   logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
   logic [LINE_W-1:0]   data_q  [SETS][WAYS];

   // ---------------------------------------------------------------- control state
   state_e                   state_q, state_d;
   core_req_t                req_q, req_d;
   logic [WAY_BITS-1:0]      victim_q, victim_d;
   logic                     rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
   logic                     rsp_hit_q, rsp_hit_d;
   logic                     mreq_valid_q, mreq_valid_d;
   logic                     mreq_we_q, mreq_we_d;
   logic [ADDRESS_WIDTH-1:0] mreq_addr_q, mreq_addr_d;
   logic [LINE_W-1:0]        mreq_wline_q, mreq_wline_d;
   logic [31:0]              hit_cnt_q, hit_cnt_d;
   logic [31:0]              miss_cnt_q, miss_cnt_d;
   logic [31:0]              wb_cnt_q, wb_cnt_d;

   // Array write controls, produced by the FSM for the set of the held request.
   logic                     meta_we;
   logic [WAYS-1:0]          meta_valid_d, meta_dirty_d, meta_use_d;
   logic                     line_we;
   logic [WAY_BITS-1:0]      line_way;
   logic [LINE_W-1:0]        line_d;

   // ---------------------------------------------------------------- request decode
   logic [INDEX_BITS-1:0] idx;
   logic [TAG_BITS-1:0]   rtag;
   logic [WSEL-1:0]       word_idx;
   logic [WAYS-1:0]       set_valid, set_dirty, set_use;

   assign idx       = req_q.addr[OFFSET_BITS +: INDEX_BITS];
   assign rtag      = req_q.addr[ADDRESS_WIDTH-1 -: TAG_BITS];
   // Byte-within-word bits drop out of the shift; only the word number remains.
   assign word_idx  = WSEL'((req_q.addr >> BYTE_BITS) & ADDRESS_WIDTH'(WORDS - 1));
   assign set_valid = valid_q[idx];
   assign set_dirty = dirty_q[idx];
   assign set_use   = use_q[idx];

   function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0]     line,
                                                    input logic [WSEL-1:0]       w,
                                                    input logic [DATA_WIDTH-1:0] d);
      logic [LINE_W-1:0] m;
      m = line;
      m[w*DATA_WIDTH +: DATA_WIDTH] = d;
      return m;
   endfunction

   // NRU: mark the touched way; if that would leave every way marked, keep
   // only the touched way so there is always an unmarked candidate.
   function automatic logic [WAYS-1:0] nru_next(input logic [WAYS-1:0] u,
                                                input logic [WAYS-1:0] oh);
      logic [WAYS-1:0] n;
      n = u | oh;
      if (&n) n = oh;
      return n;
   endfunction

   // ---------------------------------------------------------------- tag compare / victim pick
   logic [WAYS-1:0]     hit_vec;
   logic                hit;
   logic [WAY_BITS-1:0] hit_way;
   logic [WAY_BITS-1:0] vic_way;
   logic [LINE_W-1:0]   hit_line;
   logic [WAYS-1:0]     victim_oh;

   always_comb begin
      hit_vec = '0;
      hit_way = '0;
      vic_way = '0;
      for (int w = 0; w < WAYS; w++)
         hit_vec[w] = set_valid[w] && (tag_q[idx][w] == rtag);
      for (int w = WAYS - 1; w >= 0; w--)
         if (hit_vec[w]) hit_way = WAY_BITS'(w);
      // Lowest way with use=0, then overridden by the lowest invalid way if any.
      for (int w = WAYS - 1; w >= 0; w--)
         if (!set_use[w]) vic_way = WAY_BITS'(w);
      for (int w = WAYS - 1; w >= 0; w--)
         if (!set_valid[w]) vic_way = WAY_BITS'(w);
   end

   assign hit       = $onehot(hit_vec);
   assign hit_line  = data_q[idx][hit_way];
   assign victim_oh = WAYS'(1) << victim_q;

   // ---------------------------------------------------------------- FSM next state / outputs
   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      victim_d     = victim_q;
      rsp_valid_d  = 1'b0;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_hit_d    = rsp_hit_q;
      mreq_valid_d = mreq_valid_q;
      mreq_we_d    = mreq_we_q;
      mreq_addr_d  = mreq_addr_q;
      mreq_wline_d = mreq_wline_q;
      hit_cnt_d    = hit_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      wb_cnt_d     = wb_cnt_q;
      meta_we      = 1'b0;
      meta_valid_d = set_valid;
      meta_dirty_d = set_dirty;
      meta_use_d   = set_use;
      line_we      = 1'b0;
      line_way     = victim_q;
      line_d       = mem_rsp_line_i;

      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               req_d   = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i};
               state_d = S_LOOKUP;
            end
         end

         S_LOOKUP: begin
            if (hit) begin
               rsp_valid_d  = 1'b1;
               rsp_hit_d    = 1'b1;
               rsp_rdata_d  = req_q.we ? req_q.wdata
                                       : hit_line[word_idx*DATA_WIDTH +: DATA_WIDTH];
               meta_we      = 1'b1;
               meta_use_d   = nru_next(set_use, hit_vec);
               if (req_q.we) begin
                  meta_dirty_d = set_dirty | hit_vec;
                  line_we      = 1'b1;
                  line_way     = hit_way;
                  line_d       = merge_word(hit_line, word_idx, req_q.wdata);
               end
               hit_cnt_d = hit_cnt_q + 32'd1;
               state_d   = S_IDLE;
            end else begin
               miss_cnt_d   = miss_cnt_q + 32'd1;
               victim_d     = vic_way;
               mreq_valid_d = 1'b1;
               if (set_valid[vic_way] && set_dirty[vic_way]) begin
                  mreq_we_d    = 1'b1;
                  mreq_addr_d  = {tag_q[idx][vic_way], idx, {OFFSET_BITS{1'b0}}};
                  mreq_wline_d = data_q[idx][vic_way];
                  state_d      = S_WB;
               end else begin
                  mreq_we_d   = 1'b0;
                  mreq_addr_d = {rtag, idx, {OFFSET_BITS{1'b0}}};
                  state_d     = S_FILL;
               end
            end
         end

         // Write-back is posted: once accepted, the fill request goes out
         // straight away without waiting for any acknowledgement.
         S_WB: begin
            if (mem_req_ready_i) begin
               wb_cnt_d    = wb_cnt_q + 32'd1;
               mreq_we_d   = 1'b0;
               mreq_addr_d = {rtag, idx, {OFFSET_BITS{1'b0}}};
               state_d     = S_FILL;
            end
         end

         S_FILL: begin
            if (mem_req_ready_i) begin
               mreq_valid_d = 1'b0;
               state_d      = S_WAIT;
            end
         end

         S_WAIT: begin
            if (mem_rsp_valid_i) begin
               line_we      = 1'b1;
               line_way     = victim_q;
               line_d       = req_q.we ? merge_word(mem_rsp_line_i, word_idx, req_q.wdata)
                                       : mem_rsp_line_i;
               meta_we      = 1'b1;
               meta_valid_d = set_valid | victim_oh;
               meta_dirty_d = req_q.we ? (set_dirty | victim_oh) : (set_dirty & ~victim_oh);
               meta_use_d   = nru_next(set_use, victim_oh);
               rsp_valid_d  = 1'b1;
               rsp_hit_d    = 1'b0;
               rsp_rdata_d  = req_q.we ? req_q.wdata
                                       : mem_rsp_line_i[word_idx*DATA_WIDTH +: DATA_WIDTH];
               state_d      = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         req_q        <= '0;
         victim_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_hit_q    <= 1'b0;
         mreq_valid_q <= 1'b0;
         mreq_we_q    <= 1'b0;
         mreq_addr_q  <= '0;
         mreq_wline_q <= '0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
         wb_cnt_q     <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            use_q[s]   <= '0;
         end
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         victim_q     <= victim_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_hit_q    <= rsp_hit_d;
         mreq_valid_q <= mreq_valid_d;
         mreq_we_q    <= mreq_we_d;
         mreq_addr_q  <= mreq_addr_d;
         mreq_wline_q <= mreq_wline_d;
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
         wb_cnt_q     <= wb_cnt_d;
         if (meta_we) begin
            valid_q[idx] <= meta_valid_d;
            dirty_q[idx] <= meta_dirty_d;
            use_q[idx]   <= meta_use_d;
         end
      end
   end

   // Tag and line storage carry no reset; they are only meaningful behind valid.
   always_ff @(posedge clk_i) begin
      if (line_we && !rst_i) begin
         data_q[idx][line_way] <= line_d;
         tag_q[idx][line_way]  <= rtag;
      end
   end

   assign req_ready_o     = (state_q == S_IDLE);
   assign rsp_valid_o     = rsp_valid_q;
   assign rsp_rdata_o     = rsp_rdata_q;
   assign rsp_hit_o       = rsp_hit_q;
   assign mem_req_valid_o = mreq_valid_q;
   assign mem_req_we_o    = mreq_we_q;
   assign mem_req_addr_o  = mreq_addr_q;
   assign mem_req_wline_o = mreq_wline_q;
   assign hit_count_o     = hit_cnt_q;
   assign miss_count_o    = miss_cnt_q;
   assign wb_count_o      = wb_cnt_q;

endmodule

// File: tb/tb_nway_wb_cache.sv
// Directed bench for nway_wb_cache (4 ways, 256 sets, 64-byte lines).
// All stimulus is driven and all outputs sampled on the falling edge.
// A small memory model answers fills one cycle after the request handshake
// and stores write-backs; unwritten lines read as word w = line_addr + w.
module tb_nway_wb_cache;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 512;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid, rsp_hit;
   logic [DW-1:0] rsp_rdata;
   logic          mem_req_valid, mem_req_ready, mem_req_we;
   logic [AW-1:0] mem_req_addr;
   logic [LW-1:0] mem_req_wline;
   logic          mem_rsp_valid;
   logic [LW-1:0] mem_rsp_line;
   logic [31:0]   hit_count, miss_count, wb_count;

   nway_wb_cache #(.WAYS(4), .SETS(256), .LINE_BYTES(64), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_hit_o(rsp_hit),
      .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready), .mem_req_we_o(mem_req_we),
      .mem_req_addr_o(mem_req_addr), .mem_req_wline_o(mem_req_wline),
      .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_line_i(mem_rsp_line),
      .hit_count_o(hit_count), .miss_count_o(miss_count), .wb_count_o(wb_count));

   int n_run = 0;
   int n_fail = 0;
   int exp_h = 0, exp_m = 0, exp_wb = 0;

   task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
      logic [LW-1:0] l;
      for (int w = 0; w < 16; w++) l[w*32 +: 32] = a + AW'(w);
      return l;
   endfunction

   // ---------------------------------------------------------------- memory model
   logic [LW-1:0] mem [logic [AW-1:0]];
   logic          q_we [$];
   logic [AW-1:0] q_addr [$];
   int            log_rd = 0;
   int            spur_req = 0;
   logic          pend;
   logic [AW-1:0] pend_addr;

   initial begin
      logic [LW-1:0] l;
      int spur_done;
      spur_done = 0;
      pend = 1'b0;
      pend_addr = '0;
      mem_rsp_valid = 1'b0;
      mem_rsp_line = '0;
      l = pat(32'h1040);
      l[31:0] = 32'h1122_3344;
      mem[32'h1040] = l;
      forever begin
         @(negedge clk);
         mem_rsp_valid = 1'b0;
         if (pend) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_line  = mem.exists(pend_addr) ? mem[pend_addr] : pat(pend_addr);
            pend = 1'b0;
         end
         #1;
         if (spur_req != spur_done) begin
            spur_done     = spur_req;
            mem_rsp_valid = 1'b1;
            mem_rsp_line  = '1;
         end
         if (mem_req_valid && mem_req_ready && !rst) begin
            q_we.push_back(mem_req_we);
            q_addr.push_back(mem_req_addr);
            if (mem_req_we) mem[mem_req_addr] = mem_req_wline;
            else begin
               pend = 1'b1;
               pend_addr = mem_req_addr;
            end
         end
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic do_rst();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_h = 0; exp_m = 0; exp_wb = 0;
   endtask

   task automatic chk_cnt(input string tag);
      chk({tag, "_hits"}, LW'(hit_count), LW'(exp_h));
      chk({tag, "_misses"}, LW'(miss_count), LW'(exp_m));
      chk({tag, "_wbs"}, LW'(wb_count), LW'(exp_wb));
   endtask

   task automatic issue(input string tag, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      chk({tag, "_ready"}, LW'(req_ready), LW'(1));
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic finish_rsp(input string tag, input logic [DW-1:0] exp_d, input logic exp_hit);
      int lat;
      logic got;
      lat = 1;
      got = 1'b0;
      while (!got && lat < 200) begin
         if (rsp_valid) got = 1'b1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      chk({tag, "_rsp"}, LW'(got), LW'(1));
      if (got) begin
         chk({tag, "_hit"}, LW'(rsp_hit), LW'(exp_hit));
         chk({tag, "_data"}, LW'(rsp_rdata), LW'(exp_d));
         if (exp_hit) chk({tag, "_lat"}, LW'(lat), LW'(2));
         @(negedge clk);
         chk({tag, "_pulse"}, LW'(rsp_valid), LW'(0));
      end
      if (exp_hit) exp_h++;
      else exp_m++;
   endtask

   task automatic do_req(input string tag, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] exp_d, input logic exp_hit);
      issue(tag, we, a, d);
      finish_rsp(tag, exp_d, exp_hit);
   endtask

   task automatic chk_log(input string tag, input logic we, input logic [AW-1:0] a);
      chk({tag, "_logged"}, LW'(q_addr.size() > log_rd), LW'(1));
      if (q_addr.size() > log_rd) begin
         chk({tag, "_we"}, LW'(q_we[log_rd]), LW'(we));
         chk({tag, "_addr"}, LW'(q_addr[log_rd]), LW'(a));
         log_rd++;
      end
   endtask

   task automatic chk_nolog(input string tag);
      chk(tag, LW'(q_addr.size()), LW'(log_rd));
   endtask

   task automatic wait_memreq(input string tag);
      int n;
      n = 0;
      while (!mem_req_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk(tag, LW'(mem_req_valid), LW'(1));
   endtask

   task automatic hold(input string tag, input logic we, input logic [AW-1:0] a,
                       input logic [LW-1:0] line, input logic check_line, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         chk({tag, "_valid"}, LW'(mem_req_valid), LW'(1));
         chk({tag, "_we"}, LW'(mem_req_we), LW'(we));
         chk({tag, "_addr"}, LW'(mem_req_addr), LW'(a));
         chk({tag, "_ready"}, LW'(req_ready), LW'(0));
         if (check_line) chk({tag, "_wline"}, mem_req_wline, line);
         @(negedge clk);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- directed sequence
   initial begin
      logic [LW-1:0] wb_line;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      mem_req_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // reset state
      chk("rst_ready", LW'(req_ready), LW'(1));
      chk("rst_rsp_valid", LW'(rsp_valid), LW'(0));
      chk("rst_rsp_rdata", LW'(rsp_rdata), LW'(0));
      chk("rst_rsp_hit", LW'(rsp_hit), LW'(0));
      chk("rst_mreq_valid", LW'(mem_req_valid), LW'(0));
      chk("rst_mreq_we", LW'(mem_req_we), LW'(0));
      chk("rst_mreq_addr", LW'(mem_req_addr), LW'(0));
      chk("rst_mreq_wline", mem_req_wline, '0);
      chk_cnt("rst");

      // reset while a fill is outstanding
      mem_req_ready = 1'b0;
      issue("t1", 1'b0, 32'h1040, 32'h0);
      wait_memreq("t1_fill_seen");
      chk("t1_fill_addr", LW'(mem_req_addr), LW'(32'h1040));
      chk("t1_fill_we", LW'(mem_req_we), LW'(0));
      chk("t1_miss_pre", LW'(miss_count), LW'(1));
      do_rst();
      chk("t1_mreq_valid", LW'(mem_req_valid), LW'(0));
      chk("t1_ready", LW'(req_ready), LW'(1));
      chk_cnt("t1");
      mem_req_ready = 1'b1;

      // cold read then hit
      do_req("t2_cold", 1'b0, 32'h1040, 32'h0, 32'h1122_3344, 1'b0);
      chk_log("t2_fill", 1'b0, 32'h1040);
      do_req("t2_hit", 1'b0, 32'h1040, 32'h0, 32'h1122_3344, 1'b1);
      chk_cnt("t2");

      // dirty line in way0, fill ways 1-3, then evict way0
      do_rst();
      do_req("t3_wr", 1'b1, 32'h1044, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
      chk_log("t3_wr_fill", 1'b0, 32'h1040);
      do_req("t3_rd1", 1'b0, 32'h5040, 32'h0, 32'h0000_5040, 1'b0);
      chk_log("t3_rd1_fill", 1'b0, 32'h5040);
      do_req("t3_rd2", 1'b0, 32'h9040, 32'h0, 32'h0000_9040, 1'b0);
      chk_log("t3_rd2_fill", 1'b0, 32'h9040);
      do_req("t3_rd3", 1'b0, 32'hD040, 32'h0, 32'h0000_D040, 1'b0);
      chk_log("t3_rd3_fill", 1'b0, 32'hD040);

      // memory back-pressure during WB and FILL
      wb_line = pat(32'h1040);
      wb_line[31:0]  = 32'h1122_3344;
      wb_line[63:32] = 32'hDEAD_BEEF;
      mem_req_ready = 1'b0;
      issue("t4", 1'b0, 32'h11040, 32'h0);
      wait_memreq("t4_wb_seen");
      hold("t4_wb", 1'b1, 32'h1040, wb_line, 1'b1, 10);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      hold("t4_fill", 1'b0, 32'h11040, '0, 1'b0, 10);
      mem_req_ready = 1'b1;
      finish_rsp("t4", 32'h0001_1040, 1'b0);
      exp_wb++;
      chk_log("t4_wb_log", 1'b1, 32'h1040);
      chk_log("t4_fill_log", 1'b0, 32'h11040);
      chk_nolog("t4_no_extra");
      chk_cnt("t4");

      // NRU: hits on ways 1 and 2 leave only way2 marked; the next miss takes way0
      do_req("t6_h1", 1'b0, 32'h5040, 32'h0, 32'h0000_5040, 1'b1);
      do_req("t6_h2", 1'b0, 32'h9040, 32'h0, 32'h0000_9040, 1'b1);
      do_req("t6_m1", 1'b0, 32'h15040, 32'h0, 32'h0001_5040, 1'b0);
      chk_log("t6_m1_fill", 1'b0, 32'h15040);
      chk_nolog("t6_m1_no_wb");
      do_req("t6_h3", 1'b0, 32'h9040, 32'h0, 32'h0000_9040, 1'b1);
      do_req("t6_h4", 1'b0, 32'h5040, 32'h0, 32'h0000_5040, 1'b1);
      do_req("t6_m2", 1'b0, 32'h11040, 32'h0, 32'h0001_1040, 1'b0);
      chk_log("t6_m2_fill", 1'b0, 32'h11040);
      do_req("t6_h5", 1'b0, 32'h15040, 32'h0, 32'h0001_5040, 1'b1);
      chk_cnt("t6");

      // stray fill strobe while idle is ignored
      spur_req++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_rsp_valid", LW'(rsp_valid), LW'(0));
         chk("t5_ready", LW'(req_ready), LW'(1));
      end
      chk_cnt("t5");
      do_req("t5_hit", 1'b0, 32'h5040, 32'h0, 32'h0000_5040, 1'b1);

      // write hit and read back
      do_req("wh_wr", 1'b1, 32'h5048, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1);
      do_req("wh_rd", 1'b0, 32'h5048, 32'h0, 32'hCAFE_F00D, 1'b1);

      // written-back data comes back from memory; way2 is the victim
      do_req("fin_m1", 1'b0, 32'h1044, 32'h0, 32'hDEAD_BEEF, 1'b0);
      chk_log("fin_m1_fill", 1'b0, 32'h1040);
      do_req("fin_m2", 1'b0, 32'h9040, 32'h0, 32'h0000_9040, 1'b0);
      chk_log("fin_m2_fill", 1'b0, 32'h9040);
      chk_nolog("fin_no_wb");
      do_req("fin_h", 1'b0, 32'h5048, 32'h0, 32'hCAFE_F00D, 1'b1);
      chk_cnt("fin");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
